// File: rtl/div_stall_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Holds the E-stage stall while dividing and presents {HI=rem, LO=quot} with div_ready.
module div_stall_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             annul,
  output logic             div_stallE,
  output logic             div_ready,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [1:0]       stateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quot, rem, divisor;
  logic             quotNeg, remNeg, divZero;

  logic [WIDTH:0]   shifted, trial;
  logic             fits;
  logic [WIDTH-1:0] remStep, quotStep, quotFinal, remFinal;
  logic [WIDTH-1:0] absA, absB;
  logic             aNeg, bNeg, accept, lastStep;

  assign aNeg     = signedE & srcaE[WIDTH-1];
  assign bNeg     = signedE & srcbE[WIDTH-1];
  assign absA     = aNeg ? -srcaE : srcaE;
  assign absB     = bNeg ? -srcbE : srcbE;
  assign accept   = (state == IDLE) & startE & ~annul;
  assign lastStep = (count == CNT_W'(WIDTH - 1));

  // Stall is also dropped while reset is held so the pipeline is released at once.
  assign div_stallE = (((state == IDLE) & startE) | (state == BUSY)) & ~annul & ~rst;
  assign div_ready  = (state == DONE);
  assign stateDbg   = state;

  // One restoring step: shift in the next dividend bit, keep the difference if it fits.
  always_comb begin
    shifted   = {rem, quot[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    fits      = (shifted >= {1'b0, divisor});
    remStep   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quotStep  = {quot[WIDTH-2:0], fits};
    quotFinal = divZero ? '1 : (quotNeg ? -quotStep : quotStep);
    remFinal  = remNeg ? -remStep : remStep;
  end

  always_comb begin
    stateNext = state;
    if (annul) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (startE) stateNext = BUSY;
        BUSY:    if (lastStep) stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      quot    <= '0;
      rem     <= '0;
      divisor <= '0;
      quotNeg <= 1'b0;
      remNeg  <= 1'b0;
      divZero <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else if (annul) begin
      count <= '0;
    end else if (accept) begin
      quot    <= absA;
      divisor <= absB;
      rem     <= '0;
      count   <= '0;
      quotNeg <= aNeg ^ bNeg;
      remNeg  <= aNeg;
      divZero <= (srcbE == '0);
    end else if (state == BUSY) begin
      quot  <= quotStep;
      rem   <= remStep;
      count <= count + CNT_W'(1);
      if (lastStep) begin
        hi_out <= remFinal;
        lo_out <= quotFinal;
      end
    end
  end

endmodule

// File: tb/tb_div_stall_unit.sv
// Self-checking bench for div_stall_unit: directed cases, random operands against an
// arithmetic reference model, annul, back-to-back issue and asynchronous reset.
module tb_div_stall_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         startE = 1'b0;
  logic         signedE = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         annul = 1'b0;
  logic         div_stallE, div_ready;
  logic [W-1:0] hi_out, lo_out;
  logic [1:0]   stateDbg;

  int nCompared = 0;
  int nMismatch = 0;
  int doneCnt = 0;
  logic [W-1:0] lastHi = '0;
  logic [W-1:0] lastLo = '0;
  logic [2*W-1:0] exp_q[$];

  div_stall_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .startE(startE), .signedE(signedE),
    .srcaE(srcaE), .srcbE(srcbE), .annul(annul),
    .div_stallE(div_stallE), .div_ready(div_ready),
    .hi_out(hi_out), .lo_out(lo_out), .stateDbg(stateDbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (div_ready) doneCnt++;

  // Reference: MIPS DIV/DIVU semantics with wide arithmetic and the two special cases.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint la, lb, q, r;
    if (b == 0) return {a, {W{1'b1}}};
    la = s ? longint'($signed(a)) : longint'(a);
    lb = s ? longint'($signed(b)) : longint'(b);
    q = la / lb;
    r = la % lb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Issue one divide and follow it to completion; startE stays high on return.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input string name);
    logic [2*W-1:0] exp;
    int cyc, stallCnt;
    bit got;
    exp_q.push_back(ref_div(a, b, s));
    @(posedge clk); #1;
    startE = 1'b1; signedE = s; srcaE = a; srcbE = b;
    cyc = 0; stallCnt = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (div_ready) got = 1;
      else if (div_stallE) stallCnt++;
      cyc++;
    end
    exp = exp_q.pop_front();
    nCompared++;
    if (!got) begin
      nMismatch++;
      $display("FAIL %s timeout: no div_ready within %0d cycles", name, cyc);
    end else begin
      nCompared++;
      if (cyc !== W + 2) begin
        nMismatch++;
        $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, W + 2);
      end
      nCompared++;
      if (stallCnt !== W + 1) begin
        nMismatch++;
        $display("FAIL %s stall_cycles: got %0d, expected %0d", name, stallCnt, W + 1);
      end
      nCompared++;
      if (div_stallE !== 1'b0) begin
        nMismatch++;
        $display("FAIL %s stall_in_done: got %b, expected 0", name, div_stallE);
      end
      nCompared++;
      if ({hi_out, lo_out} !== exp) begin
        nMismatch++;
        $display("FAIL %s result: got hi=%h lo=%h, expected hi=%h lo=%h",
                 name, hi_out, lo_out, exp[2*W-1:W], exp[W-1:0]);
      end
    end
    lastHi = exp[2*W-1:W];
    lastLo = exp[W-1:0];
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nCompared++;
    if ({div_stallE, div_ready, hi_out, lo_out} !== '0) begin
      nMismatch++;
      $display("FAIL reset_outputs: got stall=%b ready=%b hi=%h lo=%h, expected all 0",
               div_stallE, div_ready, hi_out, lo_out);
    end
  endtask

  task automatic test_directed;
    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");     go_idle(1);
    run_div(-32'sd7, 32'd2, 1'b1, "div_m7_2");       go_idle(2);
    run_div(32'd7, -32'sd2, 1'b1, "div_7_m2");       go_idle(1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow"); go_idle(1);
    run_div(32'd5, 32'd0, 1'b0, "divu_by_zero");     go_idle(1);
    run_div(-32'sd9, 32'd0, 1'b1, "div_neg_by_zero"); go_idle(1);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1"); go_idle(1);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        2:       b = -W'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s, $sformatf("random_%0d", i));
      if ($urandom_range(0, 2) != 0) go_idle($urandom_range(1, 3));
    end
    go_idle(1);
  endtask

  task automatic test_annul;
    int d0;
    @(posedge clk); #1;
    startE = 1'b1; signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    nCompared++;
    if (div_stallE !== 1'b0) begin
      nMismatch++;
      $display("FAIL annul_stall: got %b, expected 0", div_stallE);
    end
    d0 = doneCnt;
    @(posedge clk); #1;
    annul = 1'b0; startE = 1'b0;
    repeat (40) @(negedge clk);
    nCompared++;
    if (doneCnt !== d0) begin
      nMismatch++;
      $display("FAIL annul_no_completion: got %0d completions, expected 0", doneCnt - d0);
    end
    nCompared++;
    if ({hi_out, lo_out} !== {lastHi, lastLo}) begin
      nMismatch++;
      $display("FAIL annul_hold: got hi=%h lo=%h, expected hi=%h lo=%h",
               hi_out, lo_out, lastHi, lastLo);
    end
    run_div(32'd1000, 32'd3, 1'b0, "after_annul");
    go_idle(1);
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = doneCnt;
    run_div(32'd50, 32'd6, 1'b0, "b2b_first");
    run_div(32'd12345, 32'd100, 1'b0, "b2b_second");
    go_idle(1);
    repeat (40) @(negedge clk);
    nCompared++;
    if (doneCnt - d0 !== 2) begin
      nMismatch++;
      $display("FAIL b2b_completions: got %0d, expected 2", doneCnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    startE = 1'b1; signedE = 1'b1; srcaE = 32'hDEAD_BEEF; srcbE = 32'd17;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    nCompared++;
    if ({div_stallE, div_ready, hi_out, lo_out} !== '0) begin
      nMismatch++;
      $display("FAIL reset_mid_busy: got stall=%b ready=%b hi=%h lo=%h, expected all 0",
               div_stallE, div_ready, hi_out, lo_out);
    end
    @(posedge clk); #1;
    startE = 1'b0; rst = 1'b0;
    lastHi = '0; lastLo = '0;
    run_div(32'd81, 32'd9, 1'b0, "after_reset");
    go_idle(1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_annul;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
